johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receiving end of the Johnson ring counter interface: samples a Johnson-coded bus, decodes it to a binary step index, and checks that successive samples follow the legal twisted-ring sequence. It tracks lock state, flags sequence errors, counts errors and completed laps. It sits downstream of any Johnson counter in the design, as a monitor or decoder on its output bus.

## Interface
- WIDTH, 4, number of ring stages (≥2); sequence length is 2*WIDTH.
- IW, $clog2(2*WIDTH), width of decoded index (3 for WIDTH=4).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  sample strobe; inBus is evaluated only on cycles with en=1 (one strobe per counter step).
- inBus  input  WIDTH  Johnson-coded value to decode.
- index  output  IW  decoded step index of last sampled legal code.
- legal  output  1  last sample was a legal Johnson code.
- locked  output  1  decoder is in LOCKED state.
- seqErr  output  1  one-cycle pulse: sample broke the sequence while LOCKED.
- wrap  output  1  one-cycle pulse: legal step from index 2*WIDTH-1 to 0 while LOCKED.
- errCount  output  8  sequence error count, saturating at 255.
- lapCount  output  8  completed laps, wraps modulo 256.

## Operation
- Legal codes: k ones packed at LSB end (k=0..WIDTH), or k ones packed at MSB end (k=1..WIDTH-1). For WIDTH=4: 0000,0001,0011,0111,1111,1110,1100,1000 → indices 0..7.
- Decode: p = popcount(inBus); if inBus[WIDTH-1]=0 then idx=p else idx=(2*WIDTH-p) mod 2*WIDTH. Only valid when code is legal.
- Expected successor of index i is (i+1) mod 2*WIDTH.
- FSM states: UNLOCKED, ACQUIRE, LOCKED. Transitions only on en=1:
  - UNLOCKED: legal → capture idx, go ACQUIRE; illegal → stay.
  - ACQUIRE: legal and idx = successor(index) → LOCKED; legal otherwise → recapture idx, stay ACQUIRE; illegal → UNLOCKED.
  - LOCKED: legal and idx = successor(index) → stay; if index was 2*WIDTH-1, pulse wrap, lapCount+1. Otherwise pulse seqErr, errCount+1 (saturating); legal → recapture idx, go ACQUIRE; illegal → UNLOCKED.
- index updates only on legal samples; holds its last value on illegal samples.
- legal updates on every en=1 sample; holds when en=0.
- seqErr and wrap never assert outside LOCKED; never together.
- Errors in UNLOCKED/ACQUIRE are not counted.

## Timing
- Reset (async, immediate): state UNLOCKED, index=0, legal=0, locked=0, seqErr=0, wrap=0, errCount=0, lapCount=0.
- All outputs registered; latency one cycle: sample at edge N appears on outputs after edge N.
- locked rises on the edge that accepts the second consecutive correct sample; falls on the edge that accepts a faulty sample.
- seqErr/wrap high for exactly the cycle after the offending/wrapping sample; 0 on every cycle with en=0.
- en=0: all state, counters and index hold; pulses deassert.
- Reset mid-operation clears everything including counters; first sample after reset release starts acquisition from UNLOCKED.
- errCount at 255 stays 255 on further errors; lapCount 255 → 0 on next wrap.

## Test plan
- Reset: assert rst asynchronously between edges → all outputs 0 immediately, held while rst=1.
- Clean run (WIDTH=4): en=1 every cycle, codes 0000,0001,…,1000 twice then 0000 → locked=1 after second sample, index tracks 0..7, wrap pulses twice, lapCount=2, errCount=0.
- Illegal code while LOCKED: feed 0101 after 0011 → legal=0, seqErr pulse, locked=0, errCount=1, index stays 2; then 0000,0001 → relock.
- Skip: LOCKED at 0011, feed 1111 → seqErr, errCount+1, ACQUIRE, index=4; next 1110 → locked=1, no error.
- Stall/gaps: en toggled 1/0 with inBus garbage during en=0 → no state change, no pulses, sequence continues correctly on en=1 samples.
- Saturation and reset mid-run: force 260 LOCKED errors → errCount=255; assert rst mid-lap → counters 0, locked=0, reacquire on next two samples.

Source files
------------

// File: rtl/johnson_decoder.sv
// ---------------------------------------------------------------------------
// johnson_decoder
//   Monitors a Johnson (twisted-ring) coded bus. Each strobed sample is
//   checked for being a legal Johnson code, decoded to its step index, and
//   compared against the expected successor of the previously decoded step.
//   A three-state lock FSM (UNLOCKED -> ACQUIRE -> LOCKED) tracks whether the
//   incoming sequence is being followed. Sequence errors seen while LOCKED
//   are pulsed and counted (saturating). Completed laps are pulsed and
//   counted (modulo 256).
//
// Ports
//   clk      : clock, all state updates on rising edge
//   rst      : asynchronous active-high reset
//   en       : sample strobe, inBus is only evaluated when en=1
//   inBus    : Johnson-coded input, WIDTH bits
//   index    : decoded step index of the last legal sample
//   legal    : last strobed sample was a legal Johnson code
//   locked   : FSM is in LOCKED
//   seqErr   : one-cycle pulse, sample broke the sequence while LOCKED
//   wrap     : one-cycle pulse, legal step from 2*WIDTH-1 to 0 while LOCKED
//   errCount : sequence error count, saturates at 255
//   lapCount : completed lap count, wraps modulo 256
// ---------------------------------------------------------------------------
module johnson_decoder #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] inBus,
  output logic [IW-1:0]    index,
  output logic             legal,
  output logic             locked,
  output logic             seqErr,
  output logic             wrap,
  output logic [7:0]       errCount,
  output logic [7:0]       lapCount
);

  localparam int N = 2*WIDTH;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   index_q, index_d;
  logic            legal_q, legal_d;
  logic            seqErr_q, seqErr_d;
  logic            wrap_q, wrap_d;
  logic [7:0]      err_q, err_d;
  logic [7:0]      lap_q, lap_d;

  // Sample decode
  logic [IW-1:0]   pop;
  logic [IW-1:0]   ntr;
  logic            code_ok;
  logic [IW-1:0]   idx;
  logic            last;
  logic [IW-1:0]   succ;
  logic            in_seq;

  always_comb begin
    pop = '0;
    ntr = '0;
    for (int b = 0; b < WIDTH; b++) pop = pop + IW'(inBus[b]);
    // A legal Johnson code is a single run of ones touching one end of the
    // bus, i.e. it has at most one 0/1 boundary between adjacent bits.
    for (int b = 0; b < WIDTH-1; b++) ntr = ntr + IW'(inBus[b] ^ inBus[b+1]);
    code_ok = (ntr < IW'(2));
    // MSB set means we are in the falling half of the ring; popcount >= 1
    // there, so N-pop never reaches N and needs no modulo.
    idx     = inBus[WIDTH-1] ? IW'(N - int'(pop)) : pop;
    last    = (index_q == IW'(N-1));
    succ    = last ? '0 : index_q + 1'b1;
    in_seq  = code_ok && (idx == succ);
  end

  // Next-state / output logic
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    legal_d  = legal_q;
    seqErr_d = 1'b0;
    wrap_d   = 1'b0;
    err_d    = err_q;
    lap_d    = lap_q;
    if (en) begin
      legal_d = code_ok;
      if (code_ok) index_d = idx;
      case (state_q)
        UNLOCKED: if (code_ok) state_d = ACQUIRE;
        ACQUIRE: begin
          if (!code_ok)    state_d = UNLOCKED;
          else if (in_seq) state_d = LOCKED;
        end
        LOCKED: begin
          if (in_seq) begin
            if (last) begin
              wrap_d = 1'b1;
              lap_d  = lap_q + 8'd1;
            end
          end else begin
            seqErr_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            state_d  = code_ok ? ACQUIRE : UNLOCKED;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      index_q  <= '0;
      legal_q  <= 1'b0;
      seqErr_q <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= '0;
      lap_q    <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      legal_q  <= legal_d;
      seqErr_q <= seqErr_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      lap_q    <= lap_d;
    end
  end

  assign index    = index_q;
  assign legal    = legal_q;
  assign locked   = (state_q == LOCKED);
  assign seqErr   = seqErr_q;
  assign wrap     = wrap_q;
  assign errCount = err_q;
  assign lapCount = lap_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson_decoder
//   Self-checking bench for johnson_decoder (WIDTH=4). A behavioural model
//   built from a table of legal codes tracks the expected outputs; directed
//   scenarios are followed by a randomized mix of in-sequence, skipped,
//   illegal and stalled samples.
// ---------------------------------------------------------------------------
module tb_johnson_decoder;
  localparam int WIDTH = 4;
  localparam int N     = 2*WIDTH;
  localparam int IW    = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [WIDTH-1:0] inBus = '0;
  logic [IW-1:0]    index;
  logic             legal, locked, seqErr, wrap;
  logic [7:0]       errCount, lapCount;

  johnson_decoder #(.WIDTH(WIDTH), .IW(IW)) dut (
    .clk(clk), .rst(rst), .en(en), .inBus(inBus),
    .index(index), .legal(legal), .locked(locked), .seqErr(seqErr),
    .wrap(wrap), .errCount(errCount), .lapCount(lapCount)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Legal code table, built from the packing rules
  int idx_of[int];
  int code_of[N];

  // Model state: 0 unlocked, 1 acquire, 2 locked
  int m_state, m_index, m_legal, m_seq, m_wrap, m_err, m_lap;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic build_table();
    int c;
    for (int k = 0; k <= WIDTH; k++) begin
      c = (1 << k) - 1;
      idx_of[c] = k;
      code_of[k] = c;
    end
    for (int k = 1; k < WIDTH; k++) begin
      c = ((1 << k) - 1) << (WIDTH - k);
      idx_of[c] = N - k;
      code_of[N-k] = c;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_index = 0; m_legal = 0;
    m_seq = 0; m_wrap = 0; m_err = 0; m_lap = 0;
  endtask

  task automatic model_step(input logic e, input logic [WIDTH-1:0] c);
    int ix;
    bit good;
    m_seq  = 0;
    m_wrap = 0;
    if (!e) return;
    if (idx_of.exists(int'(c))) begin
      ix = idx_of[int'(c)];
      good = (ix == (m_index + 1) % N);
      m_legal = 1;
      case (m_state)
        0: m_state = 1;
        1: if (good) m_state = 2;
        default: begin
          if (good) begin
            if (m_index == N-1) begin
              m_wrap = 1;
              m_lap  = (m_lap + 1) % 256;
            end
          end else begin
            m_seq = 1;
            if (m_err < 255) m_err++;
            m_state = 1;
          end
        end
      endcase
      m_index = ix;
    end else begin
      m_legal = 0;
      if (m_state == 2) begin
        m_seq = 1;
        if (m_err < 255) m_err++;
      end
      m_state = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".index"},    int'(index),    m_index);
    chk({tag, ".legal"},    int'(legal),    m_legal);
    chk({tag, ".locked"},   int'(locked),   (m_state == 2) ? 1 : 0);
    chk({tag, ".seqErr"},   int'(seqErr),   m_seq);
    chk({tag, ".wrap"},     int'(wrap),     m_wrap);
    chk({tag, ".errCount"}, int'(errCount), m_err);
    chk({tag, ".lapCount"}, int'(lapCount), m_lap);
  endtask

  // Called at a falling edge: drive, clock, update model, check at next fall.
  task automatic step(input string tag, input logic e, input logic [WIDTH-1:0] c);
    en = e;
    inBus = c;
    @(posedge clk);
    model_step(e, c);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic step_succ(input string tag);
    step(tag, 1'b1, WIDTH'(code_of[(m_index + 1) % N]));
  endtask

  initial begin
    logic [WIDTH-1:0] c;
    int r;
    build_table();
    model_reset();

    // Reset state
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Clean run: two full laps then 0000
    for (int lap = 0; lap < 2; lap++)
      for (int i = 0; i < N; i++) step("clean", 1'b1, WIDTH'(code_of[i]));
    step("clean", 1'b1, WIDTH'(code_of[0]));
    chk("clean_laps", int'(lapCount), 2);
    chk("clean_lock", int'(locked), 1);

    // Illegal code while locked
    step("pre_ill", 1'b1, 4'b0001);
    step("pre_ill", 1'b1, 4'b0011);
    step("illegal", 1'b1, 4'b0101);
    chk("ill_index", int'(index), 2);
    chk("ill_seqErr", int'(seqErr), 1);
    step("relock", 1'b1, 4'b0000);
    step("relock", 1'b1, 4'b0001);
    chk("relocked", int'(locked), 1);

    // Skip while locked
    step("pre_skip", 1'b1, 4'b0011);
    step("skip", 1'b1, 4'b1111);
    chk("skip_index", int'(index), 4);
    step("skip_relock", 1'b1, 4'b1110);
    chk("skip_locked", int'(locked), 1);

    // Stalls with garbage on the bus
    for (int i = 0; i < 24; i++) begin
      step_succ("stall_on");
      step("stall_off", 1'b0, WIDTH'($urandom));
    end

    // Randomized mix
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      step_succ("rnd_succ");
      else if (r == 6) step("rnd_off", 1'b0, WIDTH'($urandom));
      else if (r == 7) step("rnd_jump", 1'b1, WIDTH'(code_of[$urandom_range(0, N-1)]));
      else if (r == 8) step("rnd_any", 1'b1, WIDTH'($urandom));
      else             step("rnd_same", 1'b1, WIDTH'(code_of[m_index]));
    end

    // Error saturation: skip (error) then successor (relock), 260 times
    step_succ("sat_pre");
    step_succ("sat_pre");
    for (int i = 0; i < 260; i++) begin
      step("sat_skip", 1'b1, WIDTH'(code_of[(m_index + 3) % N]));
      step_succ("sat_lock");
    end
    chk("err_sat", int'(errCount), 255);

    // Reset mid-lap, asserted between edges
    step_succ("mid");
    step_succ("mid");
    @(posedge clk);
    model_step(en, inBus);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    rst = 1'b0;
    c = WIDTH'(code_of[5]);
    step("reacq1", 1'b1, c);
    chk("reacq1_unlocked", int'(locked), 0);
    step_succ("reacq2");
    chk("reacq2_locked", int'(locked), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
